rf_wb_arbiter: RTL and testbench

Write-back arbiter and hazard scoreboard for the register file's single write port (`we3`/`a3`/`wd3`). Two result producers compete for that port: the ALU and the load/store unit. The block grants one of them per cycle and drives the port from registered outputs. It also keeps a 32-entry busy mask so the issue stage stalls on RAW/WAW hazards against writes that have not yet landed.

---
 rtl/rf_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-back arbiter and hazard scoreboard for the register file's single
//   write port. The ALU and LSU compete for the port. The LSU normally wins.
//   After STARVE_MAX consecutive ALU denials, the ALU is forced through.
//   The granted result is registered onto we3/a3/wd3.
//   A busy mask over x1..x31 stalls the issue stage on RAW/WAW hazards
//   until the producing write lands.
//
//   Optional feature: define RF_WB_BYPASS_EN to enable the bypass outputs.
//   When enabled, the source-operand stall terms for the register being
//   written this cycle are masked.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   issue_valid/rd/rs1/rs2           issuing instruction
//   issue_stall                      combinational: instruction must not issue
//   alu_valid/rd/data, alu_ready     ALU write request and grant
//   lsu_valid/rd/data, lsu_ready     LSU write request and grant
//   we3, a3, wd3                     registered register-file write port
//   byp1_hit, byp2_hit, byp_data     bypass for rs1/rs2 (0 without bypass)
module rf_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic            byp1_hit,
  output logic            byp2_hit,
  output logic [XLEN-1:0] byp_data
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]      starve_q, starve_d;
  logic            we3_q, we3_d;
  logic [4:0]      a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic [31:0]     busy_q, busy_d;

  logic            force_alu;
  logic            accept;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     clr_vec;
  logic [31:0]     set_vec;
  logic [31:0]     src_busy;

  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

  // Arbitration: the LSU wins unless the ALU has been starved to the limit.
  always_comb begin
    force_alu = (starve_q == STARVE_LIM);
    lsu_ready = lsu_valid && !(alu_valid && force_alu);
    alu_ready = alu_valid && !lsu_ready;
    accept    = alu_ready || lsu_ready;
    sel_rd    = lsu_ready ? lsu_rd   : alu_rd;
    sel_data  = lsu_ready ? lsu_data : alu_data;
    starve_d  = (alu_valid && !alu_ready) ? starve_q + 4'd1 : 4'd0;
  end

  // Commit: a3/wd3 hold their values when nothing is accepted.
  // A request to x0 is consumed but never raises we3.
  always_comb begin
    we3_d = accept && (sel_rd != 5'd0);
    a3_d  = accept ? sel_rd   : a3_q;
    wd3_d = accept ? sel_data : wd3_q;
  end

  // Scoreboard
  always_comb begin
    clr_vec = we3_q ? (32'd1 << a3_q) : 32'd0;
`ifdef RF_WB_BYPASS_EN
    // The register being written this cycle is forwarded, so it does not
    // block source operands. The destination (WAW) term still sees it.
    src_busy = busy_q & ~clr_vec;
    byp1_hit = we3_q && (a3_q == issue_rs1) && (a3_q != 5'd0);
    byp2_hit = we3_q && (a3_q == issue_rs2) && (a3_q != 5'd0);
    byp_data = wd3_q;
`else
    src_busy = busy_q;
    byp1_hit = 1'b0;
    byp2_hit = 1'b0;
    byp_data = '0;
`endif
    issue_stall = issue_valid &&
                  (src_busy[issue_rs1] || src_busy[issue_rs2] || busy_q[issue_rd]);
    set_vec = (issue_valid && !issue_stall && (issue_rd != 5'd0)) ?
              (32'd1 << issue_rd) : 32'd0;
    // The set is applied after the clear, so a same-edge set of that index wins.
    busy_d = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
      we3_q    <= 1'b0;
      a3_q     <= 5'd0;
      wd3_q    <= '0;
      busy_q   <= 32'd0;
    end else begin
      starve_q <= starve_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic [4:0]      issue_rd, issue_rs1, issue_rs2;
  logic            issue_stall;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic            byp1_hit, byp2_hit;
  logic [XLEN-1:0] byp_data;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .we3(we3), .a3(a3), .wd3(wd3),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  // Reference model: set of pending destinations, the write in flight,
  // and how many cycles in a row the ALU has been refused.
  bit [31:0]       m_busy;
  bit              m_we;
  bit [4:0]        m_a3;
  logic [XLEN-1:0] m_wd;
  int              m_deny;
  bit              g_alu, g_lsu;

  function automatic bit src_blocked(input bit [4:0] r);
    if (r == 0) return 1'b0;
    if (!m_busy[r]) return 1'b0;
    if (BYP && m_we && m_a3 == r) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_we = 0; m_a3 = 0; m_wd = '0; m_deny = 0;
  endtask

  // Compare all outputs against the model for the current inputs,
  // then advance one clock and advance the model.
  task automatic run_cycle();
    bit e_stall, e_b1, e_b2;
    logic [XLEN-1:0] e_bd;
    bit [31:0] n_busy;
    bit n_we; bit [4:0] n_a3; logic [XLEN-1:0] n_wd; int n_deny;
    #1;
    g_lsu = lsu_valid && !(alu_valid && m_deny == STARVE_MAX);
    g_alu = alu_valid && !g_lsu;
    e_stall = issue_valid && (src_blocked(issue_rs1) || src_blocked(issue_rs2) ||
                              (issue_rd != 0 && m_busy[issue_rd]));
    e_b1 = BYP && m_we && m_a3 == issue_rs1 && m_a3 != 0;
    e_b2 = BYP && m_we && m_a3 == issue_rs2 && m_a3 != 0;
    e_bd = BYP ? m_wd : '0;
    checks++; if (alu_ready !== g_alu) begin errors++; $display("FAIL alu_ready t=%0t got %b want %b", $time, alu_ready, g_alu); end
    checks++; if (lsu_ready !== g_lsu) begin errors++; $display("FAIL lsu_ready t=%0t got %b want %b", $time, lsu_ready, g_lsu); end
    checks++; if (issue_stall !== e_stall) begin errors++; $display("FAIL issue_stall t=%0t got %b want %b", $time, issue_stall, e_stall); end
    checks++; if (we3 !== m_we) begin errors++; $display("FAIL we3 t=%0t got %b want %b", $time, we3, m_we); end
    checks++; if (a3 !== m_a3) begin errors++; $display("FAIL a3 t=%0t got %0d want %0d", $time, a3, m_a3); end
    checks++; if (wd3 !== m_wd) begin errors++; $display("FAIL wd3 t=%0t got %h want %h", $time, wd3, m_wd); end
    checks++; if ({byp1_hit, byp2_hit} !== {e_b1, e_b2}) begin errors++; $display("FAIL byp_hit t=%0t got %b%b want %b%b", $time, byp1_hit, byp2_hit, e_b1, e_b2); end
    checks++; if (byp_data !== e_bd) begin errors++; $display("FAIL byp_data t=%0t got %h want %h", $time, byp_data, e_bd); end
    n_busy = m_busy;
    if (m_we) n_busy[m_a3] = 1'b0;
    if (issue_valid && !e_stall && issue_rd != 0) n_busy[issue_rd] = 1'b1;
    n_we = 0; n_a3 = m_a3; n_wd = m_wd;
    if (g_lsu) begin n_we = (lsu_rd != 0); n_a3 = lsu_rd; n_wd = lsu_data; end
    if (g_alu) begin n_we = (alu_rd != 0); n_a3 = alu_rd; n_wd = alu_data; end
    n_deny = (alu_valid && !g_alu) ? m_deny + 1 : 0;
    @(posedge clk);
    #1;
    m_busy = n_busy; m_we = n_we; m_a3 = n_a3; m_wd = n_wd; m_deny = n_deny;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = '0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    alu_valid = 1; alu_rd = 5'd3;
    #1;
    checks++; if ({we3, a3, wd3} !== {1'b0, 5'd0, 32'd0}) begin errors++; $display("FAIL reset_regs got we3=%b a3=%0d wd3=%h want 0/0/0", we3, a3, wd3); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b want 1", alu_ready); end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_write();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_first_ready got %b want 1", alu_ready); end
    run_cycle();
    idle_inputs();
    checks++; if ({we3, a3, wd3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL alu_commit got %b/%0d/%h want 1/5/deadbeef", we3, a3, wd3); end
    run_cycle();
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL alu_commit_drop got %b want 0", we3); end
    run_cycle();
  endtask

  task automatic test_starvation();
    bit want_alu;
    idle_inputs();
    run_cycle();
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1111;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h2222;
    for (int i = 0; i < 15; i++) begin
      want_alu = (i % 5 == 4);
      #1;
      checks++;
      if ({alu_ready, lsu_ready} !== {want_alu, !want_alu}) begin
        errors++; $display("FAIL starve_pattern i=%0d got alu=%b lsu=%b want alu=%b", i, alu_ready, lsu_ready, want_alu);
      end
      run_cycle();
    end
    idle_inputs();
    run_cycle();
    run_cycle();
  endtask

  task automatic test_raw_stall();
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd7;
    run_cycle();
    issue_rd = 5'd0; issue_rs1 = 5'd7;
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_1 got %b want 1", issue_stall); end
    run_cycle();
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h12345678;
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_2 got %b want 1", issue_stall); end
    run_cycle();
    lsu_valid = 0;
    #1;
    checks++; if ({we3, a3} !== {1'b1, 5'd7}) begin errors++; $display("FAIL raw_commit got %b/%0d want 1/7", we3, a3); end
    checks++; if (issue_stall !== !BYP) begin errors++; $display("FAIL raw_stall_commit got %b want %b", issue_stall, !BYP); end
    checks++; if (byp1_hit !== BYP) begin errors++; $display("FAIL raw_byp1 got %b want %b", byp1_hit, BYP); end
    checks++; if (byp_data !== (BYP ? 32'h12345678 : 32'h0)) begin errors++; $display("FAIL raw_byp_data got %h", byp_data); end
    run_cycle();
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_unstall got %b want 0", issue_stall); end
    run_cycle();
    idle_inputs();
    run_cycle();
  endtask

  task automatic test_x0();
    idle_inputs();
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hCAFE0000;
    issue_valid = 1; issue_rd = 5'd0;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", lsu_ready); end
    run_cycle();
    lsu_valid = 0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL x0_we3 got %b want 0", we3); end
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b want 0", issue_stall); end
    run_cycle();
    idle_inputs();
    run_cycle();
  endtask

  task automatic test_same_edge();
    idle_inputs();
    // Write x3 while it is not busy, then issue rd=3 on the clearing edge.
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
    run_cycle();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 5'd3;
    #1;
    checks++; if ({we3, a3, issue_stall} !== {1'b1, 5'd3, 1'b0}) begin errors++; $display("FAIL same_edge_setup got %b/%0d/%b want 1/3/0", we3, a3, issue_stall); end
    run_cycle();
    issue_rd = 5'd0; issue_rs1 = 5'd3;
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL same_edge_set_wins got %b want 1", issue_stall); end
    run_cycle();
    alu_valid = 1; alu_rd = 5'd3; issue_valid = 0;
    run_cycle();
    idle_inputs();
    run_cycle();
    run_cycle();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd5;
    run_cycle();
    issue_rd = 5'd7;
    run_cycle();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    run_cycle();
    idle_inputs();
    issue_valid = 1; issue_rs1 = 5'd5; issue_rs2 = 5'd7;
    #1;
    checks++; if ({we3, issue_stall} !== 2'b11) begin errors++; $display("FAIL areset_pre got we3=%b stall=%b want 1/1", we3, issue_stall); end
    #1 rst_n = 0;
    #1;
    checks++; if ({we3, a3, wd3} !== {1'b0, 5'd0, 32'd0}) begin errors++; $display("FAIL areset_regs got %b/%0d/%h want 0/0/0", we3, a3, wd3); end
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", issue_stall); end
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    run_cycle();
  endtask

  task automatic test_random();
    bit alu_hold, lsu_hold;
    alu_hold = 0; lsu_hold = 0;
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_rd = 5'($urandom_range(0, 7));
        alu_data = $urandom;
      end
      if (!lsu_hold) begin
        lsu_valid = ($urandom_range(0, 2) == 0);
        lsu_rd = 5'($urandom_range(0, 7));
        lsu_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd  = 5'($urandom_range(0, 7));
      issue_rs1 = 5'($urandom_range(0, 7));
      issue_rs2 = 5'($urandom_range(0, 7));
      run_cycle();
      alu_hold = alu_valid && !g_alu;
      lsu_hold = lsu_valid && !g_lsu;
    end
    idle_inputs();
    run_cycle();
  endtask

  initial begin
    test_reset();
    model_reset();
    test_alu_write();
    test_starvation();
    test_raw_stall();
    test_x0();
    test_same_edge();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
